// File: rtl/image_pixel_streamer.sv
// Image ROM sequencer: streams one stored image, pixel by pixel, over a
// valid/ready handshake through a single-entry registered output stage.
module image_pixel_streamer #(
    parameter int IMG_PIXELS = 784,
    parameter int NUM_IMAGES = 10,
    parameter int ADDR_W     = 13,
    parameter int IDX_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [3:0]        img_sel,
    output logic              busy,
    output logic              done,
    output logic              sel_err,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    output logic [7:0]        pix_data,
    output logic [IDX_W-1:0]  pix_idx,
    output logic              pix_valid,
    output logic              pix_last,
    input  logic              pix_ready
);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

    localparam logic [IDX_W-1:0] PIX_N    = IDX_W'(IMG_PIXELS);
    localparam logic [IDX_W-1:0] PIX_LAST = IDX_W'(IMG_PIXELS - 1);
    localparam logic [3:0]       SEL_N    = 4'(NUM_IMAGES);

    state_t            state;
    logic [IDX_W-1:0]  rd_cnt;
    logic [ADDR_W-1:0] base;
    logic [IDX_W-1:0]  rd_clamp;
    logic              more;
    logic              hs;
    logic              load;

    assign more = rd_cnt < PIX_N;
    assign hs   = pix_valid & pix_ready;
    assign load = (state == STREAM) && more && (!pix_valid || pix_ready);

    // Keep the address inside the selected image once every pixel is read.
    assign rd_clamp = more ? rd_cnt : PIX_LAST;
    assign rom_addr = (state == STREAM) ? base + ADDR_W'(rd_clamp) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            base      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sel_err   <= 1'b0;
            pix_data  <= '0;
            pix_idx   <= '0;
            pix_valid <= 1'b0;
            pix_last  <= 1'b0;
        end else begin
            done    <= 1'b0;
            sel_err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (img_sel < SEL_N) begin
                            base   <= ADDR_W'(img_sel) * ADDR_W'(IMG_PIXELS);
                            rd_cnt <= '0;
                            busy   <= 1'b1;
                            state  <= STREAM;
                        end else begin
                            sel_err <= 1'b1;
                        end
                    end
                end
                STREAM: begin
                    if (load) begin
                        pix_data  <= rom_data;
                        pix_idx   <= rd_cnt;
                        pix_valid <= 1'b1;
                        pix_last  <= (rd_cnt == PIX_LAST);
                        rd_cnt    <= rd_cnt + 1'b1;
                    end else if (hs) begin
                        pix_valid <= 1'b0;
                        pix_last  <= 1'b0;
                    end
                    if (hs && pix_last) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_image_pixel_streamer.sv
// Bench for image_pixel_streamer: count-based stream model checked every
// cycle, plus literal expectations on beats, latencies and ROM contents.
module tb_image_pixel_streamer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [3:0]  img_sel;
    logic        busy;
    logic        done;
    logic        sel_err;
    logic [12:0] rom_addr;
    logic [7:0]  rom_data;
    logic [7:0]  pix_data;
    logic [9:0]  pix_idx;
    logic        pix_valid;
    logic        pix_last;
    logic        pix_ready;

    int checks = 0;
    int errors = 0;

    image_pixel_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .img_sel   (img_sel),
        .busy      (busy),
        .done      (done),
        .sel_err   (sel_err),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .pix_data  (pix_data),
        .pix_idx   (pix_idx),
        .pix_valid (pix_valid),
        .pix_last  (pix_last),
        .pix_ready (pix_ready)
    );

    function automatic logic [7:0] rom_val(input int a);
        return 8'(a ^ (a >> 8));
    endfunction

    assign rom_data = rom_val(int'(rom_addr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Stream model: an image is a count of pixels loaded into the output
    // stage and a count accepted downstream; one may be in flight.
    bit m_busy, m_done, m_err;
    int m_base, m_acc, m_loaded;
    bit m_valid, m_hs, m_load;
    int m_ea;

    int beats, busy_cyc, done_cyc, err_cyc, lat;
    int amin, amax, first_data, last_data;
    bit seen_valid;

    task automatic clear_stats();
        beats = 0; busy_cyc = 0; done_cyc = 0; err_cyc = 0; lat = 0;
        amin = 99999; amax = -1; first_data = -1; last_data = -1;
        seen_valid = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_sel_err", sel_err, 0);
            chk("rst_rom_addr", rom_addr, 0);
            chk("rst_pix_data", pix_data, 0);
            chk("rst_pix_idx", pix_idx, 0);
            chk("rst_pix_valid", pix_valid, 0);
            chk("rst_pix_last", pix_last, 0);
            m_busy = 0; m_done = 0; m_err = 0;
            m_base = 0; m_acc = 0; m_loaded = 0;
        end else begin
            m_valid = m_loaded > m_acc;
            chk("busy", busy, m_busy);
            chk("done", done, m_done);
            chk("sel_err", sel_err, m_err);
            chk("pix_valid", pix_valid, m_valid);
            if (m_valid) begin
                chk("pix_idx", pix_idx, m_acc);
                chk("pix_data", pix_data, rom_val(m_base + m_acc));
                chk("pix_last", pix_last, m_acc == 783);
            end else begin
                chk("pix_last_idle", pix_last, 0);
            end
            m_ea = (m_loaded < 784) ? m_loaded : 783;
            chk("rom_addr", rom_addr,
                (m_busy && !m_done) ? m_base + m_ea : 0);

            if (busy) busy_cyc++;
            if (done) done_cyc++;
            if (sel_err) err_cyc++;
            if (pix_valid && pix_ready) begin
                beats++;
                if (pix_idx == 0) first_data = pix_data;
                if (pix_last) last_data = pix_data;
            end
            if (busy && !done) begin
                if (int'(rom_addr) < amin) amin = int'(rom_addr);
                if (int'(rom_addr) > amax) amax = int'(rom_addr);
                if (!seen_valid && !pix_valid) lat++;
            end
            if (pix_valid) seen_valid = 1;

            // advance the model across the coming rising edge
            m_err = !m_busy && start && (img_sel >= 10);
            if (m_done) begin
                m_done = 0;
                m_busy = 0;
            end else if (m_busy) begin
                m_hs   = m_valid && pix_ready;
                m_load = (m_loaded < 784) && (!m_valid || pix_ready);
                if (m_hs && m_acc == 783) m_done = 1;
                if (m_hs) m_acc++;
                if (m_load) m_loaded++;
            end else if (start && img_sel < 10) begin
                m_busy   = 1;
                m_base   = int'(img_sel) * 784;
                m_acc    = 0;
                m_loaded = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input int sel);
        start   = 1'b1;
        img_sel = 4'(sel);
        tick();
        start   = 1'b0;
    endtask

    task automatic wait_done(input string nm, input bit rnd);
        int n = 0;
        while (!done && n < 4000) begin
            if (rnd) pix_ready = 1'($urandom_range(1));
            tick();
            n++;
        end
        pix_ready = 1'b1;
        chk({nm, "_timeout"}, done, 1);
    endtask

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        img_sel   = '0;
        pix_ready = 1'b1;
        clear_stats();
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // image 0, free-flowing sink
        clear_stats();
        go(0);
        wait_done("img0", 0);
        tick();
        tick();
        chk("img0_beats", beats, 784);
        chk("img0_busy_cycles", busy_cyc, 786);
        chk("img0_done_cycles", done_cyc, 1);
        chk("img0_first_latency", lat, 1);
        chk("img0_addr_min", amin, 0);
        chk("img0_addr_max", amax, 783);
        chk("img0_last_data", last_data, 8'h0C);

        // top image
        clear_stats();
        go(9);
        wait_done("img9", 0);
        tick();
        chk("img9_addr_min", amin, 7056);
        chk("img9_addr_max", amax, 7839);
        chk("img9_first_data", first_data, 8'h8B);
        chk("img9_last_data", last_data, 8'h81);

        // random back-pressure
        clear_stats();
        go(3);
        wait_done("img3", 1);
        tick();
        chk("img3_beats", beats, 784);
        chk("img3_first_data", first_data, 8'h39);
        chk("img3_last_data", last_data, 8'h33);

        // out-of-range select
        clear_stats();
        go(12);
        repeat (4) tick();
        chk("sel12_err_cycles", err_cyc, 1);
        chk("sel12_busy_cycles", busy_cyc, 0);
        chk("sel12_beats", beats, 0);

        // start during stream and in DONE ignored; right after DONE accepted
        clear_stats();
        go(1);
        repeat (10) tick();
        go(2);
        wait_done("img1", 0);
        chk("img1_first_data", first_data, 8'h13);
        start   = 1'b1;
        img_sel = 4'd5;
        tick();
        clear_stats();
        img_sel = 4'd4;
        tick();
        start = 1'b0;
        wait_done("img4", 0);
        tick();
        chk("img4_beats", beats, 784);
        chk("img4_first_data", first_data, 8'h4C);

        // reset mid-stream
        clear_stats();
        go(2);
        begin
            int n = 0;
            while (beats < 100 && n < 400) begin
                tick();
                n++;
            end
            chk("img2_reach_100", beats >= 100, 1);
        end
        rst_n = 1'b0;
        tick();
        tick();
        chk("midrst_done_cycles", done_cyc, 0);
        rst_n = 1'b1;
        tick();
        clear_stats();
        go(5);
        wait_done("img5", 0);
        tick();
        chk("img5_beats", beats, 784);
        chk("img5_first_data", first_data, 8'h5F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
